// File: rtl/prefetch_scheduler.sv
// Bus scheduler arbitrating sequential instruction prefetch, execution-unit accesses and queue flushes.
// Optional macro PREFETCH_SCHEDULER_STARVE_GUARD_EN forces a prefetch after three EU accesses made against an empty queue.
module prefetch_scheduler #(
  parameter int                    DEPTH              = 6,
  parameter int                    WIDTH_ADDR         = 20,
  parameter logic [WIDTH_ADDR-1:0] RESET_ADDRESS      = 20'hFFFF0,
  parameter int                    PREFETCH_THRESHOLD = 2,
  localparam int                   LEN_W              = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  eu_request,
  input  logic                  eu_write,
  input  logic [WIDTH_ADDR-1:0] eu_address,
  output logic                  eu_grant,
  output logic                  eu_done,
  input  logic                  flush,
  input  logic [WIDTH_ADDR-1:0] flush_address,
  input  logic [LEN_W-1:0]      queue_length,
  input  logic                  queue_is_empty,
  input  logic                  queue_is_full,
  output logic                  queue_write_enable,
  output logic                  queue_flush,
  output logic                  bus_request,
  output logic                  bus_write,
  output logic [WIDTH_ADDR-1:0] bus_address,
  input  logic                  bus_ready,
  output logic [WIDTH_ADDR-1:0] prefetch_address
);

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    EU_ACCESS,
    FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [WIDTH_ADDR-1:0] flush_addr_q, flush_addr_d;
  logic [WIDTH_ADDR-1:0] prefetch_addr_q, prefetch_addr_d;
  logic [WIDTH_ADDR-1:0] eu_addr_q, eu_addr_d;
  logic                  eu_write_q, eu_write_d;

  logic [LEN_W:0]        free_slots;
  logic                  prefetch_ok;
  logic                  flush_seen;
  logic                  starve_pref;

  // Free slots are computed one bit wider so a full-depth occupancy cannot wrap.
  assign free_slots  = (LEN_W+1)'(DEPTH) - {1'b0, queue_length};
  assign prefetch_ok = ({1'b0, queue_length} <= (LEN_W+1)'(DEPTH)) &&
                       (free_slots >= (LEN_W+1)'(PREFETCH_THRESHOLD)) &&
                       !queue_is_full;
  assign flush_seen  = pending_q || flush;

  assign prefetch_address = prefetch_addr_q;

`ifdef PREFETCH_SCHEDULER_STARVE_GUARD_EN
  logic [1:0] starve_cnt_q, starve_cnt_d;

  assign starve_pref = (starve_cnt_q == 2'd3) && prefetch_ok;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (flush) begin
      starve_cnt_d = 2'd0;
    end else if (state_q == PREFETCH && bus_ready) begin
      starve_cnt_d = 2'd0;
    end else if (state_q == EU_ACCESS && bus_ready && queue_is_empty &&
                 starve_cnt_q != 2'd3) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 2'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_queue_is_empty;

  assign unused_queue_is_empty = queue_is_empty;
  assign starve_pref           = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    pending_d          = pending_q;
    flush_addr_d       = flush_addr_q;
    prefetch_addr_d    = prefetch_addr_q;
    eu_addr_d          = eu_addr_q;
    eu_write_d         = eu_write_q;
    eu_grant           = 1'b0;
    eu_done            = 1'b0;
    queue_write_enable = 1'b0;
    queue_flush        = 1'b0;
    bus_request        = 1'b0;
    bus_write          = 1'b0;
    bus_address        = '0;

    // A flush strobe is remembered in every state; the latest address wins.
    if (flush) begin
      pending_d    = 1'b1;
      flush_addr_d = flush_address;
    end

    case (state_q)
      IDLE: begin
        if (flush_seen) begin
          state_d = FLUSH;
        end else if (starve_pref) begin
          state_d = PREFETCH;
        end else if (eu_request) begin
          state_d    = EU_ACCESS;
          eu_addr_d  = eu_address;
          eu_write_d = eu_write;
        end else if (prefetch_ok) begin
          state_d = PREFETCH;
        end
      end

      PREFETCH: begin
        bus_request = 1'b1;
        bus_address = prefetch_addr_q;
        if (bus_ready) begin
          state_d = IDLE;
          // Data fetched from the old stream is discarded once a flush is known.
          if (!flush_seen && !queue_is_full) begin
            queue_write_enable = 1'b1;
            prefetch_addr_d    = prefetch_addr_q + 1'b1;
          end
        end
      end

      EU_ACCESS: begin
        bus_request = 1'b1;
        bus_address = eu_addr_q;
        bus_write   = eu_write_q;
        eu_grant    = 1'b1;
        if (bus_ready) begin
          eu_done = 1'b1;
          state_d = IDLE;
        end
      end

      FLUSH: begin
        queue_flush     = 1'b1;
        prefetch_addr_d = flush_addr_q;
        pending_d       = flush;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      pending_q       <= 1'b0;
      flush_addr_q    <= '0;
      prefetch_addr_q <= RESET_ADDRESS;
      eu_addr_q       <= '0;
      eu_write_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      flush_addr_q    <= flush_addr_d;
      prefetch_addr_q <= prefetch_addr_d;
      eu_addr_q       <= eu_addr_d;
      eu_write_q      <= eu_write_d;
    end
  end

endmodule

// File: doc/prefetch_scheduler.md
PREFETCH_SCHEDULER -- requirements
Module: prefetch_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 6, prefetch queue depth in entries.
- WIDTH_ADDR, 20, physical address width.
- RESET_ADDRESS, 20'hFFFF0, prefetch pointer value after reset.
- PREFETCH_THRESHOLD, 2, minimum free queue slots (DEPTH - queue_length) before a prefetch starts.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- eu_request, in, 1, execution-unit memory access request, held until eu_done.
- eu_write, in, 1, 1 = EU write, 0 = EU read.
- eu_address, in, WIDTH_ADDR, EU access address.
- eu_grant, out, 1, high while the EU transaction owns the bus.
- eu_done, out, 1, one-cycle pulse when the EU transaction completes.
- flush, in, 1, one-cycle jump strobe.
- flush_address, in, WIDTH_ADDR, new prefetch address, sampled with flush.
- queue_length, in, $clog2(DEPTH), current queue occupancy.
- queue_is_empty, in, 1, queue empty flag.
- queue_is_full, in, 1, queue full flag.
- queue_write_enable, out, 1, one-cycle push of fetched data into the queue.
- queue_flush, out, 1, one-cycle queue pointer clear.
- bus_request, out, 1, bus transaction active.
- bus_write, out, 1, transaction direction.
- bus_address, out, WIDTH_ADDR, transaction address.
- bus_ready, in, 1, memory completes the current transaction this cycle.
- prefetch_address, out, WIDTH_ADDR, next sequential fetch address.

Function
REQ-003 FSM states SHALL be IDLE, PREFETCH, EU_ACCESS, FLUSH.
REQ-004 In IDLE, priority SHALL be: pending or current flush -> FLUSH; eu_request -> EU_ACCESS; otherwise free slots >= PREFETCH_THRESHOLD and !queue_is_full -> PREFETCH; otherwise stay in IDLE.
REQ-005 In PREFETCH and EU_ACCESS, the block SHALL assert bus_request and hold bus_address and bus_write stable until the cycle bus_ready is sampled high; that cycle SHALL complete the transaction, and the next state SHALL be IDLE.
REQ-006 In PREFETCH: bus_address = prefetch_address and bus_write = 0; on completion without a pending flush, queue_write_enable SHALL pulse in the same cycle, and prefetch_address SHALL increment by 1 modulo 2^WIDTH_ADDR (0xFFFFF wraps to 0x00000).
REQ-007 In EU_ACCESS: bus_address and bus_write SHALL be latched from eu_address and eu_write on entry; eu_grant SHALL be high for the whole state; eu_done SHALL pulse in the completion cycle.
REQ-008 A flush arriving in any state SHALL set a pending-flush flag. In-flight bus transactions are never aborted.
REQ-009 A prefetch that completes while a flush is pending SHALL NOT assert queue_write_enable and SHALL NOT increment prefetch_address.
REQ-010 FLUSH SHALL last exactly one cycle: queue_flush = 1, prefetch_address <= latched flush_address, pending flag cleared, next state IDLE.
REQ-011 Multiple flushes before FLUSH is reached SHALL keep the last flush_address.
REQ-012 A flush in the same cycle FLUSH executes SHALL re-arm the pending flag with the new address.
REQ-013 queue_write_enable SHALL never assert while queue_is_full = 1; a prefetch SHALL never start when free slots < PREFETCH_THRESHOLD.
REQ-014 Minimum latency SHALL be: IDLE decision -> bus_request high 1 cycle later; bus_ready high in the first cycle -> 2-cycle transaction.

Reset
REQ-015 On reset = 1 at a clock edge, the following SHALL take effect regardless of state, including mid-transaction:
- state = IDLE, pending flag = 0, prefetch_address = RESET_ADDRESS.
- All outputs = 0.

Configuration
REQ-016 With PREFETCH_SCHEDULER_STARVE_GUARD_EN defined:
- A 2-bit counter SHALL count consecutive EU_ACCESS completions made while queue_is_empty = 1.
- When the counter reaches 3, the next IDLE decision SHALL choose PREFETCH over eu_request if the prefetch condition holds; flush retains top priority.
- The counter SHALL clear on any prefetch completion, on flush, and on reset.
REQ-017 Without PREFETCH_SCHEDULER_STARVE_GUARD_EN, strict EU-over-prefetch priority SHALL apply and the counter logic SHALL be absent.

Verification
REQ-018 After reset, queue_length = 0 and bus_ready tied high -> prefetches at 0xFFFF0, 0xFFFF1, ..., each with one queue_write_enable pulse; the block SHALL stop after queue_length reaches 5 (free slots = 1).
REQ-019 eu_request with eu_address = 0x01234 and eu_write = 1 raised during a prefetch, bus_ready delayed 3 cycles -> prefetch completes first; then bus_address = 0x01234, bus_write = 1, eu_grant high; eu_done pulses once.
REQ-020 flush with flush_address = 0x00100 during a prefetch awaiting bus_ready -> no queue_write_enable on completion; one-cycle queue_flush; next prefetch at 0x00100.
REQ-021 prefetch_address = 0xFFFFF, fetch completes -> prefetch_address = 0x00000.
REQ-022 reset asserted mid EU_ACCESS -> next cycle: bus_request = 0, eu_grant = 0, eu_done never pulses, prefetch_address = 0xFFFF0.
REQ-023 With the macro defined, queue empty and eu_request held continuously -> after 3 EU completions, one prefetch SHALL be granted; without the macro, no prefetch occurs.
